// File: rtl/tone_div_pkg.sv
// Shared types and constants for the multi-channel tone divider.
package tone_div_pkg;

   localparam int DEFAULT_CNT_W = 32;

   typedef enum logic {
      MODE_SQUARE = 1'b0,
      MODE_PULSE  = 1'b1
   } tone_mode_e;

   typedef struct packed {
      logic [DEFAULT_CNT_W-1:0] div;
      tone_mode_e               mode;
      logic                     enable;
   } tone_cfg_t;

   // Channel-select width; a single channel still needs a 1-bit select.
   function automatic int ch_sel_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/tone_div_channel.sv
// One divider channel: counter, pending-reload register and output stage.
module tone_div_channel
   import tone_div_pkg::*;
#(
   parameter int               CNT_W       = DEFAULT_CNT_W,
   parameter logic [CNT_W-1:0] DEFAULT_DIV = '0
)
(
   input  logic             inclk,
   input  logic             reset,
   input  logic             wr_sel,
   input  logic [CNT_W-1:0] wr_div,
   input  tone_mode_e       wr_mode,
   input  logic             wr_enable,
   input  logic             sync_all,
   output logic             out_clk,
   output logic             out_tick,
   output logic [CNT_W-1:0] active_div
);

   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] div_q, div_d;
   logic [CNT_W-1:0] pend_div_q, pend_div_d;
   tone_mode_e       mode_q, mode_d;
   tone_mode_e       pend_mode_q, pend_mode_d;
   logic             pend_valid_q, pend_valid_d;
   logic             enable_q, enable_d;
   logic             clk_q, clk_d;
   logic             tick_q, tick_d;
   logic             terminal;

   // Unsigned compare so a count left above a smaller reloaded divide still terminates.
   assign terminal = (count_q >= div_q);

   // Next-state: immediate config, phase sync, idle, terminal reload, or counting.
   always_comb begin
      count_d      = count_q;
      div_d        = div_q;
      pend_div_d   = pend_div_q;
      mode_d       = mode_q;
      pend_mode_d  = pend_mode_q;
      pend_valid_d = pend_valid_q;
      enable_d     = enable_q;
      clk_d        = clk_q;
      tick_d       = 1'b0;

      if (wr_sel && (!enable_q || !wr_enable || sync_all)) begin
         enable_d     = wr_enable;
         div_d        = wr_div;
         mode_d       = wr_mode;
         count_d      = '0;
         clk_d        = 1'b0;
         pend_valid_d = 1'b0;
      end else if (sync_all) begin
         if (enable_q) begin
            count_d = '0;
            clk_d   = 1'b0;
         end
         if (pend_valid_q) begin
            div_d        = pend_div_q;
            mode_d       = pend_mode_q;
            pend_valid_d = 1'b0;
         end
      end else if (!enable_q) begin
         count_d = '0;
         clk_d   = 1'b0;
      end else if (terminal) begin
         // A write landing on the terminal edge bypasses the pending register.
         count_d = '0;
         tick_d  = 1'b1;
         if (wr_sel) begin
            div_d        = wr_div;
            mode_d       = wr_mode;
            pend_valid_d = 1'b0;
         end else if (pend_valid_q) begin
            div_d        = pend_div_q;
            mode_d       = pend_mode_q;
            pend_valid_d = 1'b0;
         end
         clk_d = (mode_d == MODE_SQUARE) ? ~clk_q : 1'b1;
      end else begin
         count_d = count_q + CNT_W'(1);
         if (wr_sel) begin
            pend_div_d   = wr_div;
            pend_mode_d  = wr_mode;
            pend_valid_d = 1'b1;
         end
         if (mode_q == MODE_PULSE) begin
            clk_d = 1'b0;
         end
      end
   end

   // State register with synchronous reset.
   always_ff @(posedge inclk) begin
      if (reset) begin
         count_q      <= '0;
         div_q        <= DEFAULT_DIV;
         pend_div_q   <= DEFAULT_DIV;
         mode_q       <= MODE_SQUARE;
         pend_mode_q  <= MODE_SQUARE;
         pend_valid_q <= 1'b0;
         enable_q     <= 1'b0;
         clk_q        <= 1'b0;
         tick_q       <= 1'b0;
      end else begin
         count_q      <= count_d;
         div_q        <= div_d;
         pend_div_q   <= pend_div_d;
         mode_q       <= mode_d;
         pend_mode_q  <= pend_mode_d;
         pend_valid_q <= pend_valid_d;
         enable_q     <= enable_d;
         clk_q        <= clk_d;
         tick_q       <= tick_d;
      end
   end

   assign out_clk    = clk_q;
   assign out_tick   = tick_q;
   assign active_div = div_q;

endmodule

// File: rtl/multi_channel_tone_divider.sv
// N-channel programmable clock divider / tone generator: write decode and sync fan-out.
module multi_channel_tone_divider
   import tone_div_pkg::*;
#(
   parameter int               NUM_CH      = 4,
   parameter int               CNT_W       = DEFAULT_CNT_W,
   parameter logic [CNT_W-1:0] DEFAULT_DIV = '0,
   localparam int              CH_W        = ch_sel_width(NUM_CH)
)
(
   input  logic                    inclk,
   input  logic                    reset,
   input  logic                    wr_en,
   input  logic [CH_W-1:0]         wr_ch,
   input  logic [CNT_W-1:0]        wr_div,
   input  logic                    wr_mode,
   input  logic                    wr_enable,
   input  logic                    sync_all,
   output logic [NUM_CH-1:0]       out_clk,
   output logic [NUM_CH-1:0]       out_tick,
   output logic [NUM_CH*CNT_W-1:0] active_div
);

   logic wr_valid;

   // Writes to channel numbers beyond NUM_CH are dropped.
   assign wr_valid = wr_en && ({1'b0, wr_ch} < (CH_W+1)'(NUM_CH));

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic sel;
      assign sel = wr_valid && (wr_ch == CH_W'(i));

      tone_div_channel #(
         .CNT_W       (CNT_W),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_ch (
         .inclk      (inclk),
         .reset      (reset),
         .wr_sel     (sel),
         .wr_div     (wr_div),
         .wr_mode    (tone_mode_e'(wr_mode)),
         .wr_enable  (wr_enable),
         .sync_all   (sync_all),
         .out_clk    (out_clk[i]),
         .out_tick   (out_tick[i]),
         .active_div (active_div[i*CNT_W +: CNT_W])
      );
   end

endmodule

// File: tb/tb_multi_channel_tone_divider.sv
// Self-checking bench: directed test-plan steps plus random traffic against a cycle model.
module tb_multi_channel_tone_divider;

   localparam int               NUM_CH  = 3;
   localparam int               CNT_W   = 32;
   localparam int               CH_W    = 2;
   localparam logic [CNT_W-1:0] DEF_DIV = 32'd3;

   logic                    inclk = 1'b0;
   logic                    reset = 1'b1;
   logic                    wr_en = 1'b0;
   logic [CH_W-1:0]         wr_ch = '0;
   logic [CNT_W-1:0]        wr_div = '0;
   logic                    wr_mode = 1'b0;
   logic                    wr_enable = 1'b0;
   logic                    sync_all = 1'b0;
   logic [NUM_CH-1:0]       out_clk;
   logic [NUM_CH-1:0]       out_tick;
   logic [NUM_CH*CNT_W-1:0] active_div;

   int n_pass  = 0;
   int n_total = 0;

   // Model: cycles into the current period, terminals since the last restart.
   bit          m_en   [NUM_CH];
   bit          m_mode [NUM_CH];
   int unsigned m_div  [NUM_CH];
   bit          m_pv   [NUM_CH];
   int unsigned m_pdiv [NUM_CH];
   bit          m_pmode[NUM_CH];
   int unsigned m_cyc  [NUM_CH];
   int unsigned m_terms[NUM_CH];
   bit          m_tick [NUM_CH];

   multi_channel_tone_divider #(
      .NUM_CH      (NUM_CH),
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEF_DIV)
   ) dut (
      .inclk      (inclk),
      .reset      (reset),
      .wr_en      (wr_en),
      .wr_ch      (wr_ch),
      .wr_div     (wr_div),
      .wr_mode    (wr_mode),
      .wr_enable  (wr_enable),
      .sync_all   (sync_all),
      .out_clk    (out_clk),
      .out_tick   (out_tick),
      .active_div (active_div)
   );

   always #5 inclk = ~inclk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
   endtask

   task automatic model_restart(input int c);
      m_cyc[c]   = 0;
      m_terms[c] = 0;
   endtask

   task automatic model_step();
      for (int c = 0; c < NUM_CH; c++) begin
         bit sel;
         sel = wr_en && (int'(wr_ch) == c);
         if (reset) begin
            m_en[c] = 0; m_mode[c] = 0; m_div[c] = DEF_DIV; m_pdiv[c] = DEF_DIV;
            m_pv[c] = 0; m_pmode[c] = 0; m_tick[c] = 0;
            model_restart(c);
         end else if (sel && (!m_en[c] || !wr_enable || sync_all)) begin
            m_en[c] = wr_enable; m_mode[c] = wr_mode; m_div[c] = wr_div;
            m_pv[c] = 0; m_tick[c] = 0;
            model_restart(c);
         end else if (sync_all) begin
            m_tick[c] = 0;
            if (m_en[c]) model_restart(c);
            if (m_pv[c]) begin
               m_div[c] = m_pdiv[c]; m_mode[c] = m_pmode[c]; m_pv[c] = 0;
            end
         end else if (!m_en[c]) begin
            m_tick[c] = 0;
            model_restart(c);
         end else if (m_cyc[c] >= m_div[c]) begin
            m_tick[c] = 1;
            m_cyc[c]  = 0;
            m_terms[c]++;
            if (sel) begin
               m_div[c] = wr_div; m_mode[c] = wr_mode; m_pv[c] = 0;
            end else if (m_pv[c]) begin
               m_div[c] = m_pdiv[c]; m_mode[c] = m_pmode[c]; m_pv[c] = 0;
            end
         end else begin
            m_tick[c] = 0;
            m_cyc[c]++;
            if (sel) begin
               m_pdiv[c] = wr_div; m_pmode[c] = wr_mode; m_pv[c] = 1;
            end
         end
      end
   endtask

   task automatic check_all();
      for (int c = 0; c < NUM_CH; c++) begin
         bit exp_clk;
         exp_clk = m_en[c] && (m_mode[c] ? m_tick[c] : (m_terms[c] % 2 == 1));
         check($sformatf("model out_clk[%0d]", c), out_clk[c], exp_clk);
         check($sformatf("model out_tick[%0d]", c), out_tick[c], m_tick[c]);
         check($sformatf("model active_div[%0d]", c), active_div[c*CNT_W +: CNT_W], m_div[c]);
      end
   endtask

   task automatic tick_cycle();
      @(posedge inclk);
      model_step();
      #1;
      check_all();
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) tick_cycle();
   endtask

   task automatic wr(input int ch, input int unsigned div, input bit mode, input bit ena);
      wr_en = 1'b1; wr_ch = CH_W'(ch); wr_div = div; wr_mode = mode; wr_enable = ena;
      tick_cycle();
      wr_en = 1'b0;
   endtask

   // Cycles until the selected output reaches level; -1 if the bound expires.
   task automatic wait_for(input int ch, input bit use_tick, input bit level, output int n);
      n = -1;
      for (int k = 1; k <= 100; k++) begin
         tick_cycle();
         if ((use_tick ? out_tick[ch] : out_clk[ch]) == level) begin
            n = k;
            break;
         end
      end
   endtask

   initial begin
      int n;

      // Reset state
      run(2);
      reset = 1'b0;
      check("rst out_clk", out_clk, '0);
      check("rst out_tick", out_tick, '0);
      for (int c = 0; c < NUM_CH; c++)
         check($sformatf("rst active_div[%0d]", c), active_div[c*CNT_W +: CNT_W], DEF_DIV);

      // ch0 square div=4: 5-cycle half periods, tick every 5
      wr(0, 4, 0, 1);
      check("ch0 active_div", active_div[0 +: CNT_W], 4);
      wait_for(0, 0, 1, n); check("ch0 first rise", n, 5);
      wait_for(0, 0, 0, n); check("ch0 high phase", n, 5);
      wait_for(0, 1, 1, n); check("ch0 tick spacing", n, 5);

      // ch1 square div=9, reload to 2 mid half-period
      wr(1, 9, 0, 1);
      run(3);
      wr(1, 2, 0, 1);
      check("ch1 div held", active_div[CNT_W +: CNT_W], 9);
      wait_for(1, 0, 1, n); check("ch1 old half complete", n, 6);
      check("ch1 div applied", active_div[CNT_W +: CNT_W], 2);
      wait_for(1, 0, 0, n); check("ch1 new high phase", n, 3);
      wait_for(1, 0, 1, n); check("ch1 new low phase", n, 3);

      // ch2 pulse div=3, then div=0 constant high
      wr(2, 3, 1, 1);
      wait_for(2, 1, 1, n); check("ch2 first tick", n, 4);
      check("ch2 pulse with tick", out_clk[2], 1);
      wait_for(2, 1, 1, n); check("ch2 tick spacing", n, 4);
      wr(2, 0, 1, 1);
      run(6);
      for (int k = 0; k < 5; k++) begin
         tick_cycle();
         check("ch2 div0 high", out_clk[2], 1);
      end

      // sync_all with ch0 div=4, ch1 div=6
      wr(1, 6, 0, 1);
      run(10);
      sync_all = 1'b1;
      tick_cycle();
      sync_all = 1'b0;
      check("sync out_clk low", out_clk, '0);
      check("sync no tick", out_tick, '0);
      check("sync ch1 div", active_div[CNT_W +: CNT_W], 6);
      wait_for(0, 0, 1, n); check("sync ch0 rise", n, 5);
      wait_for(1, 0, 1, n); check("sync ch1 rise after ch0", n, 2);

      // Write to a nonexistent channel changes nothing
      wr(3, 1, 1, 1);
      check("bad ch ch0 div", active_div[0 +: CNT_W], 4);
      check("bad ch ch1 div", active_div[CNT_W +: CNT_W], 6);
      check("bad ch ch2 div", active_div[2*CNT_W +: CNT_W], 0);

      // Disable ch0
      wr(0, 4, 0, 0);
      for (int k = 0; k < 10; k++) begin
         check("ch0 disabled low", out_clk[0], 0);
         tick_cycle();
      end

      // Reset mid-period
      wr(0, 4, 0, 1);
      run(7);
      reset = 1'b1;
      tick_cycle();
      reset = 1'b0;
      check("midrst out_clk", out_clk, '0);
      check("midrst out_tick", out_tick, '0);
      for (int c = 0; c < NUM_CH; c++)
         check($sformatf("midrst active_div[%0d]", c), active_div[c*CNT_W +: CNT_W], DEF_DIV);
      for (int k = 0; k < 10; k++) begin
         tick_cycle();
         check("post-rst idle", out_clk, '0);
      end

      // Random traffic; running channels keep their mode across deferred reloads
      for (int k = 0; k < 800; k++) begin
         int c;
         c         = int'($urandom_range(0, 3));
         wr_en     = ($urandom_range(0, 5) == 0);
         wr_ch     = CH_W'(c);
         wr_div    = 32'($urandom_range(0, 7));
         wr_enable = ($urandom_range(0, 4) != 0);
         sync_all  = ($urandom_range(0, 39) == 0);
         reset     = ($urandom_range(0, 199) == 0);
         if (c < NUM_CH && m_en[c] && wr_enable && !sync_all)
            wr_mode = m_mode[c];
         else
            wr_mode = ($urandom_range(0, 1) == 1);
         tick_cycle();
      end
      wr_en = 1'b0; sync_all = 1'b0; reset = 1'b0;
      run(2);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/multi_channel_tone_divider.md
Name: multi_channel_tone_divider

Overview:
- Parametrised N-channel programmable clock divider and tone generator. Each channel has its own divide count, enable and output mode.
- Successor to the single-channel divider. Adds per-channel configuration through a write port, glitch-free reload at period boundaries, a pulse/strobe mode, a tick output and a global phase-sync.
- Sits between the RTOS-driven control registers and the audio/VGA timing consumers in the music player.

Parameters:
- NUM_CH, 4, number of independent divider channels (1..16).
- CNT_W, 32, width of the divide count and of each channel counter.
- DEFAULT_DIV, 0, divide count loaded into every channel at reset.
- CH_W, $clog2(NUM_CH) (min 1), derived width of the channel select. Not for override.

Ports:
- inclk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  single-cycle configuration write strobe.
- wr_ch  in  CH_W  target channel of the write.
- wr_div  in  CNT_W  new divide count.
- wr_mode  in  1  0 = square (toggle), 1 = pulse.
- wr_enable  in  1  channel enable written with the configuration.
- sync_all  in  1  single-cycle strobe; restarts all channels in phase.
- out_clk  out  NUM_CH  per-channel divided output.
- out_tick  out  NUM_CH  per-channel one-cycle strobe at each terminal count.
- active_div  out  NUM_CH*CNT_W  currently applied divide count per channel (channel i at bits [i*CNT_W +: CNT_W]).

Behaviour:
- Reset (reset=1 at a clock edge):
  - every count=0, out_clk=0, out_tick=0, enable=0, mode=0.
  - active and pending divide = DEFAULT_DIV; pending_valid=0.
  - Reset overrides all other inputs in the same cycle and may occur mid-period; the next cycle starts from the reset state.
- Terminal count: count >= active_div. On terminal, count<=0 and out_tick pulses high for exactly one cycle (the cycle after the terminal edge). Otherwise count<=count+1. Unsigned compare; a count above active_div after a reload is still terminal.
- Mode 0, square: out_clk toggles on each terminal. Half-period = div+1 cycles, period = 2*(div+1). div=0 gives inclk/2.
- Mode 1, pulse: out_clk is high for the one cycle following a terminal, else low. Period = div+1. div=0 gives out_clk constantly high.
- Disabled channel: count held at 0, out_clk=0, out_tick=0.
- Write handling (wr_en=1):
  - wr_ch >= NUM_CH: write ignored.
  - Target channel disabled, or wr_enable=0: wr_div, wr_mode and wr_enable apply on the next edge. count<=0, out_clk<=0, pending cleared.
  - Target channel enabled and wr_enable=1: wr_div and wr_mode go to pending, pending_valid<=1. They are applied at the next terminal, where count<=0 and out_clk continues its normal toggle/pulse. No runt or glitch pulse.
  - Write in the same cycle as that channel's terminal: the new value applies at this terminal directly.
  - Back-to-back writes before a terminal: last write wins.
- sync_all=1:
  - every enabled channel gets count<=0 and out_clk<=0.
  - pending values are applied.
  - out_tick is not asserted for this edge.
  - A simultaneous wr_en is applied immediately, as for a disabled channel.
- Latency: configuration to first terminal of the new period is at most the old active_div+1 cycles. active_div updates on the same edge the value is applied.
- No combinational path from any input to any output.

Decomposition:
- Package tone_div_pkg holds:
  - typedef enum logic {MODE_SQUARE=0, MODE_PULSE=1} tone_mode_e.
  - the per-channel config struct {div, mode, enable}.
  - localparam DEFAULT_CNT_W=32.
- Sub-module tone_div_channel (one counter, pending register, reload logic, output stage), instantiated NUM_CH times by a generate loop. The top level handles write decode and sync_all fan-out only.

Test Plan:
- Reset, then write ch0 div=4, mode 0, enable=1 -> out_clk[0] period 10 cycles at 50% duty. out_tick[0] every 5 cycles. active_div[0]=4.
- Ch1 running div=9 mode 0; write div=2 mid half-period -> current half-period completes at 10 cycles, following half-periods are 3 cycles. No high/low phase shorter than 3 cycles.
- Ch2 mode 1 div=3 -> out_clk[2] is a 1-cycle pulse every 4 cycles, coincident with out_tick[2]. Div=0 -> out_clk[2] constantly high.
- Ch0 div=4 and ch1 div=6 free-running, assert sync_all -> both outputs low, both counts 0 the next cycle. First toggles follow exactly 5 and 7 cycles later. No tick on the sync cycle.
- Write with wr_ch=NUM_CH (only when NUM_CH is not a power of two, e.g. NUM_CH=3 with wr_ch=3) -> no channel state changes. Write wr_enable=0 to ch0 -> out_clk[0]=0 the next cycle and stays 0.
- Assert reset for 1 cycle mid-period with ch0 running -> all outputs 0, active_div=DEFAULT_DIV, channels disabled until rewritten.
